// File: rtl/alsu_pkg.sv
// Shared ALSU command definitions: field widths, in_cmd bit positions and the
// packed command type used by the command queue and its storage.
package alsu_pkg;

    localparam int CMD_W     = 16;
    localparam int OPERAND_W = 3;
    localparam int OPCODE_W  = 3;

    localparam int CIN_BIT       = 15;
    localparam int SERIAL_IN_BIT = 14;
    localparam int A_LSB         = 11;
    localparam int B_LSB         = 8;
    localparam int OPCODE_LSB    = 5;
    localparam int RED_OP_A_BIT  = 4;
    localparam int RED_OP_B_BIT  = 3;
    localparam int BYPASS_A_BIT  = 2;
    localparam int BYPASS_B_BIT  = 1;
    localparam int DIRECTION_BIT = 0;

    typedef struct packed {
        logic                 cin;
        logic                 serial_in;
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
        logic [OPCODE_W-1:0]  opcode;
        logic                 red_op_a;
        logic                 red_op_b;
        logic                 bypass_a;
        logic                 bypass_b;
        logic                 direction;
    } alsu_cmd_t;

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Circular command buffer with wrapping pointers and full/empty flags.
// ALSU_CMD_LEVEL_EN additionally exports the registered occupancy as level.
module alsu_cmd_fifo
    import alsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [CMD_W-1:0]         wr_data,
    output logic [CMD_W-1:0]         rd_data,
    output logic                     full,
`ifdef ALSU_CMD_LEVEL_EN
    output logic [$clog2(DEPTH):0]   level,
`endif
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    alsu_cmd_t        mem [DEPTH];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= alsu_cmd_t'(wr_data);
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);

`ifdef ALSU_CMD_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: rtl/alsu_cmd_queue.sv
// ALSU command queue: buffers packed commands and issues them, unpacked and
// registered, to the ALSU register stage. ALSU_CMD_LEVEL_EN adds level/overrun.
module alsu_cmd_queue
    import alsu_pkg::*;
#(
    parameter int         DEPTH       = 4,
    parameter logic [2:0] IDLE_OPCODE = 3'b000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CMD_W-1:0]       in_cmd,
    input  logic                   issue_en,
    input  logic                   flush,
    output logic                   cin,
    output logic                   serial_in,
    output logic [OPERAND_W-1:0]   A,
    output logic [OPERAND_W-1:0]   B,
    output logic [OPCODE_W-1:0]    opcode,
    output logic                   red_op_A,
    output logic                   red_op_B,
    output logic                   bypass_A,
    output logic                   bypass_B,
    output logic                   direction,
`ifdef ALSU_CMD_LEVEL_EN
    output logic [$clog2(DEPTH):0] level,
    output logic                   overrun,
`endif
    output logic                   out_valid
);

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] head;

    // Pop only sees earlier content, so an empty queue is never bypassed.
    assign in_ready = rst && !fifo_full && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = issue_en && !flush && !fifo_empty;

    alsu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (in_cmd),
        .rd_data (head),
        .full    (fifo_full),
`ifdef ALSU_CMD_LEVEL_EN
        .level   (level),
`endif
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            out_valid <= 1'b0;
            cin       <= 1'b0;
            serial_in <= 1'b0;
            A         <= '0;
            B         <= '0;
            opcode    <= IDLE_OPCODE;
            red_op_A  <= 1'b0;
            red_op_B  <= 1'b0;
            bypass_A  <= 1'b0;
            bypass_B  <= 1'b0;
            direction <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            cin       <= head[CIN_BIT];
            serial_in <= head[SERIAL_IN_BIT];
            A         <= head[A_LSB +: OPERAND_W];
            B         <= head[B_LSB +: OPERAND_W];
            opcode    <= head[OPCODE_LSB +: OPCODE_W];
            red_op_A  <= head[RED_OP_A_BIT];
            red_op_B  <= head[RED_OP_B_BIT];
            bypass_A  <= head[BYPASS_A_BIT];
            bypass_B  <= head[BYPASS_B_BIT];
            direction <= head[DIRECTION_BIT];
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALSU_CMD_LEVEL_EN
    always_ff @(posedge clk) begin
        if (!rst || flush)
            overrun <= 1'b0;
        else if (in_valid && fifo_full)
            overrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_alsu_cmd_queue.sv
// Self-checking bench for alsu_cmd_queue: directed scenarios plus random
// traffic, all checked every cycle against a queue-based reference model.
module tb_alsu_cmd_queue;

    localparam int          DEPTH     = 4;
    localparam logic [2:0]  IDLE_OP   = 3'b101;
    localparam logic [15:0] IDLE_WORD = {8'h00, IDLE_OP, 5'b00000};

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_cmd;
    logic        issue_en;
    logic        flush;
    logic        cin, serial_in;
    logic [2:0]  A, B, opcode;
    logic        red_op_A, red_op_B, bypass_A, bypass_B, direction;
    logic        out_valid;
`ifdef ALSU_CMD_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
    logic                   overrun;
`endif

    alsu_cmd_queue #(
        .DEPTH       (DEPTH),
        .IDLE_OPCODE (IDLE_OP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cmd    (in_cmd),
        .issue_en  (issue_en),
        .flush     (flush),
        .cin       (cin),
        .serial_in (serial_in),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .red_op_A  (red_op_A),
        .red_op_B  (red_op_B),
        .bypass_A  (bypass_A),
        .bypass_B  (bypass_B),
        .direction (direction),
`ifdef ALSU_CMD_LEVEL_EN
        .level     (level),
        .overrun   (overrun),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] out_word;
    assign out_word = {cin, serial_in, A, B, opcode, red_op_A, red_op_B,
                       bypass_A, bypass_B, direction};

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model_q[$];
    logic [15:0] obs[$];
    logic [15:0] exp_word  = IDLE_WORD;
    logic        exp_valid = 1'b0;
    logic        exp_ovr   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, check in_ready, advance model and DUT, check outputs.
    task automatic cycle(input logic r, input logic v, input logic [15:0] c,
                         input logic ie, input logic fl);
        int   pre;
        logic rdy;
        rst = r; in_valid = v; in_cmd = c; issue_en = ie; flush = fl;
        #1;
        pre = model_q.size();
        rdy = r && (pre < DEPTH) && !fl;
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (!r || fl) begin
            model_q.delete();
            exp_valid = 1'b0;
            exp_word  = IDLE_WORD;
            exp_ovr   = 1'b0;
        end else begin
            if (v && pre == DEPTH)
                exp_ovr = 1'b1;
            if (ie && pre > 0) begin
                exp_word  = model_q.pop_front();
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            if (v && rdy)
                model_q.push_back(c);
        end
        #1;
        chk("out_valid", out_valid, exp_valid);
        chk("fields", out_word, exp_word);
        if (out_valid)
            obs.push_back(out_word);
`ifdef ALSU_CMD_LEVEL_EN
        chk("level", level, model_q.size());
        chk("overrun", overrun, exp_ovr);
`endif
    endtask

    logic [15:0] w[10];

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_cmd = '0; issue_en = 1'b0; flush = 1'b0;

        // reset held two cycles with a producer offering
        cycle(0, 1, 16'hABCD, 1, 0);
        cycle(0, 1, 16'hABCD, 1, 0);
        chk("rst_opcode", opcode, IDLE_OP);
        cycle(1, 0, 16'h0000, 0, 0);

        // ordering with back-to-back issue
        obs.delete();
        cycle(1, 1, 16'h8A5C, 1, 0);
        cycle(1, 1, 16'h1234, 1, 0);
        cycle(1, 1, 16'hFFFF, 1, 0);
        cycle(1, 0, 16'h0000, 1, 0);
        cycle(1, 0, 16'h0000, 1, 0);
        chk("ord_cnt", obs.size(), 3);
        chk("ord0", obs[0], 16'h8A5C);
        chk("ord1", obs[1], 16'h1234);
        chk("ord2", obs[2], 16'hFFFF);

        // fill past full with issue disabled
        for (int i = 0; i < 5; i++)
            cycle(1, 1, 16'h1000 + 16'(i), 0, 0);
        chk("full_ready", in_ready, 1'b0);

        // flush with three queued and a coincident push
        cycle(1, 0, 16'h0000, 0, 1);
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 16'h2000 + 16'(i), 0, 0);
        obs.delete();
        cycle(1, 1, 16'hBEEF, 1, 1);
        cycle(1, 0, 16'h0000, 1, 0);
        cycle(1, 1, 16'h0001, 1, 0);
        cycle(1, 0, 16'h0000, 1, 0);
        cycle(1, 0, 16'h0000, 1, 0);
        chk("flush_cnt", obs.size(), 1);
        chk("flush_next", obs[0], 16'h0001);

        // wrap-around at occupancy three
        obs.delete();
        for (int i = 0; i < 10; i++)
            w[i] = 16'($urandom);
        for (int i = 0; i < 3; i++)
            cycle(1, 1, w[i], 0, 0);
        for (int i = 3; i < 10; i++)
            cycle(1, 1, w[i], 1, 0);
        for (int i = 0; i < 4; i++)
            cycle(1, 0, 16'h0000, 1, 0);
        chk("wrap_cnt", obs.size(), 10);
        for (int i = 0; i < 10; i++)
            chk("wrap_word", obs[i], w[i]);

        // hold after a single issue
        cycle(1, 1, 16'h5A3C, 0, 0);
        cycle(1, 0, 16'h0000, 1, 0);
        for (int i = 0; i < 5; i++)
            cycle(1, 0, 16'h0000, 0, 0);
        chk("hold_word", out_word, 16'h5A3C);

        // random traffic including mid-operation reset and flush
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 16'($urandom),
                  $urandom_range(0, 99) < (i < 200 ? 30 : 80), $urandom_range(0, 24) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
